// File: rtl/temp_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : temp_monitor_if
// Purpose  : 8-bit Wishbone slave bundle for the temperature monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface temp_monitor_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic        stall;
  logic [7:0]  rdata;

  modport master (output cyc, stb, we, addr, wdata, input ack, stall, rdata);
  modport slave  (input cyc, stb, we, addr, wdata, output ack, stall, rdata);
endinterface
`default_nettype wire

// File: rtl/temp_monitor.sv
`default_nettype none
// ============================================================================
// Module   : temp_monitor
// Purpose  : Block-averages sensor samples, tracks min/max, raises a
//            hysteresis over-temperature alarm; Wishbone register access.
// Revision : 1.0 - initial release
// ============================================================================
module temp_monitor #(
  parameter int                N_RES      = 7,
  parameter int                AVG_LOG2   = 2,
  parameter logic [31:0]       BASE_ADDR  = 32'h3000_0040,
  parameter logic [N_RES-1:0]  THR_HI_RST = 7'd40,
  parameter logic [N_RES-1:0]  THR_LO_RST = 7'd35
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_res_valid,
  input  logic [N_RES-1:0] i_res,
  output logic             o_alarm,
  output logic             o_avg_valid,
  temp_monitor_if.slave    wb
);

  localparam int                  c_ACC_W    = N_RES + AVG_LOG2;
  localparam logic [28:0]         c_BASE_TAG = BASE_ADDR[31:3];
  localparam logic [AVG_LOG2-1:0] c_CNT_LAST = '1;
  localparam logic [N_RES-1:0]    c_MIN_RST  = '1;

  logic [c_ACC_W-1:0]  r_acc;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [N_RES-1:0]    r_avg;
  logic [N_RES-1:0]    r_min;
  logic [N_RES-1:0]    r_max;
  logic [N_RES-1:0]    r_thr_hi;
  logic [N_RES-1:0]    r_thr_lo;
  logic                r_avg_upd;
  logic                r_avg_valid;
  logic                r_alarm;
  logic                r_ack;
  logic [7:0]          r_rdata;

  logic                w_sel;
  logic                w_wr;
  logic                w_rd;
  logic [2:0]          w_off;
  logic                w_clr_mm;
  logic                w_clr_al;
  logic                w_block_done;
  logic [c_ACC_W-1:0]  w_acc_sum;
  logic [N_RES-1:0]    w_min_base;
  logic [N_RES-1:0]    w_max_base;
  logic [7:0]          w_rdata;
  logic                w_unused_wdata;

  assign w_sel        = wb.cyc & wb.stb & (wb.addr[31:3] == c_BASE_TAG);
  assign w_wr         = w_sel & wb.we;
  assign w_rd         = w_sel & ~wb.we;
  assign w_off        = wb.addr[2:0];
  assign w_clr_mm     = w_wr & (w_off == 3'd6) & wb.wdata[0];
  assign w_clr_al     = w_wr & (w_off == 3'd6) & wb.wdata[1];
  assign w_block_done = i_res_valid & (r_cnt == c_CNT_LAST);
  assign w_acc_sum    = r_acc + c_ACC_W'(i_res);
  // A same-cycle clear is applied first so the new sample seeds min/max.
  assign w_min_base   = w_clr_mm ? c_MIN_RST : r_min;
  assign w_max_base   = w_clr_mm ? '0 : r_max;
  assign w_unused_wdata = &{1'b0, wb.wdata[7:N_RES]};

  always_comb begin
    w_rdata = '0;
    case (w_off)
      3'd0:    w_rdata = 8'(r_avg);
      3'd1:    w_rdata = 8'(r_min);
      3'd2:    w_rdata = 8'(r_max);
      3'd3:    w_rdata = {5'b0, (r_cnt != '0), r_avg_valid, r_alarm};
      3'd4:    w_rdata = 8'(r_thr_hi);
      3'd5:    w_rdata = 8'(r_thr_lo);
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_avg     <= '0;
      r_avg_upd <= 1'b0;
    end else begin
      r_avg_upd <= 1'b0;
      if (w_block_done) begin
        r_avg     <= w_acc_sum[c_ACC_W-1:AVG_LOG2];
        r_acc     <= '0;
        r_cnt     <= '0;
        r_avg_upd <= 1'b1;
      end else if (i_res_valid) begin
        r_acc <= w_acc_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_min <= c_MIN_RST;
      r_max <= '0;
    end else begin
      r_min <= (i_res_valid && (i_res < w_min_base)) ? i_res : w_min_base;
      r_max <= (i_res_valid && (i_res > w_max_base)) ? i_res : w_max_base;
    end
  end

  // Evaluation reads the pre-edge thresholds and overrides a CTRL clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alarm     <= 1'b0;
      r_avg_valid <= 1'b0;
    end else begin
      if (r_avg_upd) begin
        if (r_avg > r_thr_hi)      r_alarm <= 1'b1;
        else if (r_avg < r_thr_lo) r_alarm <= 1'b0;
      end else if (w_clr_al) begin
        r_alarm <= 1'b0;
      end
      if (w_block_done)  r_avg_valid <= 1'b1;
      else if (w_clr_al) r_avg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_thr_hi <= THR_HI_RST;
      r_thr_lo <= THR_LO_RST;
      r_ack    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_ack <= w_sel;
      if (w_rd) r_rdata <= w_rdata;
      if (w_wr && (w_off == 3'd4)) r_thr_hi <= wb.wdata[N_RES-1:0];
      if (w_wr && (w_off == 3'd5)) r_thr_lo <= wb.wdata[N_RES-1:0];
    end
  end

  assign o_alarm     = r_alarm;
  assign o_avg_valid = r_avg_valid;
  assign wb.ack      = r_ack;
  assign wb.rdata    = r_rdata;
  assign wb.stall    = 1'b0;

endmodule
`default_nettype wire
